// File: rtl/issue_rat_freelist.sv
// Free list of physical registers for the 64-entry RAT: a circular FIFO that hands out free PRFs
// at rename and takes PRFs back from commit-time release and from checkpoint abandonment.
module issue_rat_freelist #(
    parameter int PRF_WIDTH = 6,
    parameter int FGR_WIDTH = 3,
    parameter int PTR_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_alloc_valid,
    input  logic [FGR_WIDTH-1:0] i_alloc_fgr,
    output logic                 o_alloc_ready,
    output logic [PRF_WIDTH-1:0] o_alloc_prf,
    output logic                 o_acquired_valid,
    input  logic                 i_acquired_ready,
    output logic [FGR_WIDTH-1:0] o_acquired_fgr,
    output logic [PRF_WIDTH-1:0] o_acquired_prf,
    input  logic                 i_abandoned_valid,
    output logic                 o_abandoned_ready,
    input  logic [PRF_WIDTH-1:0] i_abandoned_prf,
    input  logic                 i_release_valid,
    input  logic [PRF_WIDTH-1:0] i_release_prf,
    output logic [PTR_WIDTH:0]   o_free_count,
    output logic                 o_overflow
);
    localparam int DEPTH      = 2 ** PTR_WIDTH;
    localparam int ARCH_COUNT = 2 ** PRF_WIDTH - DEPTH;

    logic [PRF_WIDTH-1:0] entry_reg [DEPTH];
    logic [PTR_WIDTH-1:0] rptr_reg, rptr_next;
    logic [PTR_WIDTH-1:0] wptr_reg, wptr_next;
    logic [PTR_WIDTH-1:0] abd_addr;
    logic [PTR_WIDTH:0]   count_reg, count_next;
    logic                 overflow_reg, overflow_next;

    logic empty, full, pop, push_rel, push_abd, rel_drop;
    logic [DEPTH-1:0] rel_we, abd_we;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == (PTR_WIDTH+1)'(DEPTH));

    assign o_acquired_valid = i_alloc_valid & ~empty;
    assign o_alloc_ready    = i_alloc_valid & ~empty & i_acquired_ready;
    assign pop              = o_alloc_ready;
    assign o_alloc_prf      = empty ? '0 : entry_reg[rptr_reg];
    assign o_acquired_prf   = o_alloc_prf;
    assign o_acquired_fgr   = i_alloc_fgr;

    // Abandoned returns are throttled on the registered count alone, leaving room for a release.
    assign o_abandoned_ready = ({1'b0, count_reg} + (PTR_WIDTH+2)'(i_release_valid))
                               < (PTR_WIDTH+2)'(DEPTH);

    // A release into a full list still fits when the head slot is popped in the same cycle.
    assign push_rel = i_release_valid & (~full | pop);
    assign rel_drop = i_release_valid & full & ~pop;
    assign push_abd = i_abandoned_valid & o_abandoned_ready;
    assign abd_addr = wptr_reg + PTR_WIDTH'(push_rel);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
            assign rel_we[gi] = push_rel && (wptr_reg == PTR_WIDTH'(gi));
            assign abd_we[gi] = push_abd && (abd_addr == PTR_WIDTH'(gi));
        end
    endgenerate

    always_comb begin
        rptr_next     = rptr_reg + PTR_WIDTH'(pop);
        wptr_next     = wptr_reg + PTR_WIDTH'(push_rel) + PTR_WIDTH'(push_abd);
        count_next    = count_reg + (PTR_WIDTH+1)'(push_rel) + (PTR_WIDTH+1)'(push_abd)
                        - (PTR_WIDTH+1)'(pop);
        overflow_next = overflow_reg | rel_drop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                entry_reg[k] <= PRF_WIDTH'(ARCH_COUNT + k);
            end
            rptr_reg     <= '0;
            wptr_reg     <= '0;
            count_reg    <= (PTR_WIDTH+1)'(DEPTH);
            overflow_reg <= 1'b0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (rel_we[k]) begin
                    entry_reg[k] <= i_release_prf;
                end else if (abd_we[k]) begin
                    entry_reg[k] <= i_abandoned_prf;
                end
            end
            rptr_reg     <= rptr_next;
            wptr_reg     <= wptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    assign o_free_count = count_reg;
    assign o_overflow   = overflow_reg;
endmodule

// File: tb/tb_issue_rat_freelist.sv
// Directed bench for the PRF free list: allocation order, backpressure, dual push, overflow, wrap.
module tb_issue_rat_freelist;
    logic       clk = 1'b0;
    logic       reset;
    logic       i_alloc_valid;
    logic [2:0] i_alloc_fgr;
    logic       o_alloc_ready;
    logic [5:0] o_alloc_prf;
    logic       o_acquired_valid;
    logic       i_acquired_ready;
    logic [2:0] o_acquired_fgr;
    logic [5:0] o_acquired_prf;
    logic       i_abandoned_valid;
    logic       o_abandoned_ready;
    logic [5:0] i_abandoned_prf;
    logic       i_release_valid;
    logic [5:0] i_release_prf;
    logic [5:0] o_free_count;
    logic       o_overflow;

    int checks   = 0;
    int failures = 0;
    int q[$];
    int exp_prf;

    issue_rat_freelist dut (
        .clk               (clk),
        .reset             (reset),
        .i_alloc_valid     (i_alloc_valid),
        .i_alloc_fgr       (i_alloc_fgr),
        .o_alloc_ready     (o_alloc_ready),
        .o_alloc_prf       (o_alloc_prf),
        .o_acquired_valid  (o_acquired_valid),
        .i_acquired_ready  (i_acquired_ready),
        .o_acquired_fgr    (o_acquired_fgr),
        .o_acquired_prf    (o_acquired_prf),
        .i_abandoned_valid (i_abandoned_valid),
        .o_abandoned_ready (o_abandoned_ready),
        .i_abandoned_prf   (i_abandoned_prf),
        .i_release_valid   (i_release_valid),
        .i_release_prf     (i_release_prf),
        .o_free_count      (o_free_count),
        .o_overflow        (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            $display("check %-22s observed=%0d expected=%0d ok", tag, obs, exp);
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        i_alloc_valid = 0; i_alloc_fgr = 0; i_acquired_ready = 0;
        i_abandoned_valid = 0; i_abandoned_prf = 0; i_release_valid = 0; i_release_prf = 0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_count", 32'(o_free_count), 32);
        chk("rst_prf", 32'(o_alloc_prf), 32);
        chk("rst_overflow", 32'(o_overflow), 0);
        chk("rst_abd_ready", 32'(o_abandoned_ready), 0);

        // Checkpoint backpressure: valid offered, no pop.
        i_alloc_valid = 1; i_alloc_fgr = 3'd5; i_acquired_ready = 0;
        #1;
        chk("bp_acq_valid", 32'(o_acquired_valid), 1);
        chk("bp_alloc_ready", 32'(o_alloc_ready), 0);
        chk("bp_acq_fgr", 32'(o_acquired_fgr), 5);
        chk("bp_acq_prf", 32'(o_acquired_prf), 32);
        tick();
        chk("bp_count_held", 32'(o_free_count), 32);
        chk("bp_prf_held", 32'(o_alloc_prf), 32);

        // Drain all 32 free PRFs back to back.
        i_acquired_ready = 1;
        for (int i = 0; i < 32; i++) begin
            i_alloc_fgr = 3'(i);
            #1;
            chk("drain_ready", 32'(o_alloc_ready), 1);
            chk("drain_prf", 32'(o_alloc_prf), 32'(32 + i));
            tick();
        end
        chk("empty_count", 32'(o_free_count), 0);
        chk("empty_ready", 32'(o_alloc_ready), 0);
        chk("empty_acq_valid", 32'(o_acquired_valid), 0);
        chk("empty_prf", 32'(o_alloc_prf), 0);

        // Release and abandoned in the same cycle on an empty list.
        i_release_valid = 1; i_release_prf = 6'd5;
        i_abandoned_valid = 1; i_abandoned_prf = 6'd9;
        #1;
        chk("dual_abd_ready", 32'(o_abandoned_ready), 1);
        chk("dual_no_bypass", 32'(o_alloc_ready), 0);
        tick();
        i_release_valid = 0; i_abandoned_valid = 0;
        #1;
        chk("dual_count", 32'(o_free_count), 2);
        chk("dual_first_rdy", 32'(o_alloc_ready), 1);
        chk("dual_first_prf", 32'(o_alloc_prf), 5);
        tick();
        chk("dual_second_prf", 32'(o_alloc_prf), 9);
        tick();
        i_alloc_valid = 0;
        chk("dual_drained", 32'(o_free_count), 0);

        // Fill to 31 with releases 10..40.
        for (int i = 0; i < 31; i++) begin
            i_release_valid = 1; i_release_prf = 6'(10 + i);
            tick();
        end
        chk("fill_count", 32'(o_free_count), 31);
        i_release_prf = 6'd41;
        i_abandoned_valid = 1; i_abandoned_prf = 6'd50;
        #1;
        chk("c31_abd_ready", 32'(o_abandoned_ready), 0);
        tick();
        i_abandoned_valid = 0;
        chk("c31_count", 32'(o_free_count), 32);
        chk("c31_overflow", 32'(o_overflow), 0);

        // Release into a full list with no pop.
        i_release_prf = 6'd60;
        tick();
        i_release_valid = 0;
        chk("ovf_set", 32'(o_overflow), 1);
        chk("ovf_count", 32'(o_free_count), 32);
        chk("ovf_head_intact", 32'(o_alloc_prf), 10);
        tick();
        chk("ovf_sticky", 32'(o_overflow), 1);

        // Pop + release each cycle across pointer wrap.
        for (int i = 10; i <= 41; i++) q.push_back(i);
        i_alloc_valid = 1; i_acquired_ready = 1;
        for (int i = 0; i < 40; i++) begin
            i_release_valid = 1; i_release_prf = 6'((i * 7 + 3) % 64);
            exp_prf = q.pop_front();
            q.push_back((i * 7 + 3) % 64);
            #1;
            chk("wrap_prf", 32'(o_alloc_prf), 32'(exp_prf));
            tick();
            chk("wrap_count", 32'(o_free_count), 32);
        end
        i_alloc_valid = 0; i_release_valid = 0;
        #1;
        chk("wrap_next_prf", 32'(o_alloc_prf), 32'(q[0]));

        // Reset clears overflow and restores the initial free set.
        reset = 1;
        tick();
        reset = 0;
        #1;
        chk("rst2_overflow", 32'(o_overflow), 0);
        chk("rst2_count", 32'(o_free_count), 32);
        chk("rst2_prf", 32'(o_alloc_prf), 32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
